ff_out_checker: RTL
===================

FF_OUT_CHECKER -- requirements
Module: ff_out_checker

Interface
REQ-001 Parameter WIDTH, default 4: width of stimulus and observed data.
REQ-002 Parameter WARMUP, default 2: cycles spent in ARM before comparison starts, range 0..255.
REQ-003 Parameter ERR_LIMIT, default 4: mismatch count that forces FAULT, range 1..255.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  pulse; begins or restarts a check run.
REQ-007 stop  input  1  pulse; ends a run that is in CHECK.
REQ-008 en  input  1  enable driven to the flop under test.
REQ-009 in  input  WIDTH  data driven to the flop under test.
REQ-010 dut_q  input  WIDTH  registered output of the flop under test.
REQ-011 state  output  3  FSM state: IDLE=0, ARM=1, CHECK=2, DONE=3, FAULT=4.
REQ-012 busy  output  1  high in ARM or CHECK.
REQ-013 pass  output  1  high in DONE when err_cnt==0.
REQ-014 fail  output  1  high in FAULT, or in DONE when err_cnt!=0.
REQ-015 err_cnt  output  8  mismatch count for the current run.
REQ-016 cyc_cnt  output  16  compare cycles executed in the current run.

Function
REQ-017 Reference model exp[WIDTH-1:0] SHALL load in on every rising edge where en=1 and hold otherwise, in all states.
REQ-018 Mismatch SHALL be defined as dut_q != exp at a rising edge, evaluated only in CHECK.
REQ-019 IDLE: start SHALL go to ARM and clear err_cnt, cyc_cnt, and the warmup counter; other inputs ignored.
REQ-020 ARM: SHALL count WARMUP edges with no comparison, then enter CHECK; WARMUP=0 SHALL enter CHECK on the edge after start.
REQ-021 CHECK: each edge SHALL increment cyc_cnt, saturating at 16'hFFFF, and increment err_cnt on mismatch, saturating at 255.
REQ-022 CHECK: when an edge's mismatch makes err_cnt equal ERR_LIMIT, the next state SHALL be FAULT.
REQ-023 CHECK: stop without a limit-reaching mismatch SHALL go to DONE; a mismatch on the stop edge SHALL still be counted.
REQ-024 Simultaneous stop and limit-reaching mismatch: FAULT SHALL take priority over DONE.
REQ-025 start during ARM or CHECK SHALL be ignored; stop outside CHECK SHALL be ignored.
REQ-026 DONE and FAULT: counters SHALL hold; start SHALL clear counters and re-enter ARM.
REQ-027 All outputs SHALL be registered or decoded from registered state only, with no combinational path from inputs.

Reset
REQ-028 rst=1 at a rising edge SHALL force state=IDLE, exp=0, err_cnt=0, cyc_cnt=0, busy=0, pass=0, fail=0; rst SHALL override start, stop, and any run in progress.

Configuration
REQ-029 Macro FFC_FIRST_ERR_CAPTURE_EN, when defined, SHALL add outputs first_exp[WIDTH-1:0], first_obs[WIDTH-1:0], first_cyc[15:0], and first_vld.
REQ-030 With the macro defined, these outputs SHALL latch exp, dut_q, and cyc_cnt (pre-increment) on the first mismatch of a run and set first_vld=1.
REQ-031 With the macro defined, these outputs SHALL clear on rst or start.
REQ-032 Without the macro, these ports and their registers SHALL NOT exist; all other behaviour SHALL be identical.

Verification
REQ-033 Reset, start, then drive en=1 with in=4'h5, 4'hA, 4'h3 and dut_q as a correct one-cycle-delayed copy for 10 CHECK cycles, then stop -> state=DONE, pass=1, err_cnt=0, cyc_cnt=10.
REQ-034 Same run with dut_q forced to 4'hF on 2 CHECK cycles -> DONE, fail=1, err_cnt=2; with the macro defined, first_obs=4'hF at the first forced cycle's cyc_cnt.
REQ-035 dut_q stuck at 4'h0 while in=4'h9 and en=1 -> FAULT on the 4th CHECK edge, err_cnt=4, busy=0; a later stop leaves the state at FAULT.
REQ-036 en=0 with in toggling and dut_q holding the last enabled value 4'h6 -> no mismatches, err_cnt=0.
REQ-037 stop asserted on the same edge as the 4th mismatch -> FAULT, not DONE; start in CHECK -> no effect on counters.
REQ-038 rst asserted mid-CHECK with err_cnt=3 -> next edge state=IDLE with all outputs at reset values; WARMUP=0 run -> CHECK on the first edge after start.

Source files
------------

// File: rtl/ff_out_checker.sv
// Checks a flop under test against a reference register that loads `in` whenever `en` is high.
// The optional first-mismatch capture outputs exist only when FFC_FIRST_ERR_CAPTURE_EN is defined.
module ff_out_checker #(
  parameter int WIDTH     = 4,
  parameter int WARMUP    = 2,
  parameter int ERR_LIMIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic [WIDTH-1:0] in,
  input  logic [WIDTH-1:0] dut_q,
  output logic [2:0]       state,
  output logic             busy,
  output logic             pass,
  output logic             fail,
  output logic [7:0]       err_cnt,
  output logic [15:0]      cyc_cnt
`ifdef FFC_FIRST_ERR_CAPTURE_EN
  ,
  output logic [WIDTH-1:0] first_exp,
  output logic [WIDTH-1:0] first_obs,
  output logic [15:0]      first_cyc,
  output logic             first_vld
`endif
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ARM   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  // ARM always lasts at least one edge, so WARMUP of 0 and 1 both leave on the first ARM edge.
  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);
  localparam logic [7:0] ERR_LIM   = 8'(ERR_LIMIT);

  // start and stop are single-cycle pulses sampled on the rising edge; there is no
  // valid/ready handshake, a pulse arriving in a state that does not accept it is dropped.

  logic [WIDTH-1:0] ref_q;
  logic [7:0]       warm_cnt;
  logic [7:0]       warm_nxt;
  logic [2:0]       state_nxt;
  logic             run_clear;
  logic             mismatch;
  logic             limit_hit;
  logic [7:0]       err_inc;
  logic [15:0]      cyc_inc;

  always_comb begin
    mismatch  = (state == S_CHECK) && (dut_q != ref_q);
    err_inc   = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;
    cyc_inc   = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
    limit_hit = mismatch && (err_cnt != 8'hFF) && ((err_cnt + 8'd1) == ERR_LIM);
  end

  always_comb begin
    state_nxt = state;
    warm_nxt  = warm_cnt;
    run_clear = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_FAULT: begin
        if (start) begin
          state_nxt = S_ARM;
          run_clear = 1'b1;
        end
      end
      S_ARM: begin
        if (warm_cnt == WARM_LAST) begin
          state_nxt = S_CHECK;
        end else begin
          warm_nxt = warm_cnt + 8'd1;
        end
      end
      S_CHECK: begin
        // A limit-reaching mismatch wins over a simultaneous stop.
        if (limit_hit) begin
          state_nxt = S_FAULT;
        end else if (stop) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ref_q    <= '0;
      err_cnt  <= 8'd0;
      cyc_cnt  <= 16'd0;
      warm_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (en) begin
        ref_q <= in;
      end
      if (run_clear) begin
        err_cnt  <= 8'd0;
        cyc_cnt  <= 16'd0;
        warm_cnt <= 8'd0;
      end else begin
        warm_cnt <= warm_nxt;
        if (state == S_CHECK) begin
          cyc_cnt <= cyc_inc;
          if (mismatch) begin
            err_cnt <= err_inc;
          end
        end
      end
    end
  end

  always_comb begin
    busy = (state == S_ARM) || (state == S_CHECK);
    pass = (state == S_DONE) && (err_cnt == 8'd0);
    fail = (state == S_FAULT) || ((state == S_DONE) && (err_cnt != 8'd0));
  end

`ifdef FFC_FIRST_ERR_CAPTURE_EN
  always_ff @(posedge clk) begin
    if (rst || run_clear) begin
      first_exp <= '0;
      first_obs <= '0;
      first_cyc <= 16'd0;
      first_vld <= 1'b0;
    end else if (mismatch && !first_vld) begin
      first_exp <= ref_q;
      first_obs <= dut_q;
      first_cyc <= cyc_cnt;
      first_vld <= 1'b1;
    end
  end
`endif

endmodule
